conv_out_requant: RTL
=====================

Name: conv_out_requant

Overview:
- Stage directly downstream of conv_128_32. Consumes its 21-bit signed y stream: rounds, shifts, optional ReLU, saturates to 8-bit signed.
- Buffers results in a small FIFO and tags the last sample of each 97-output frame.
- Decouples conv backpressure from the consumer; sustains 1 sample/cycle when the consumer is always ready.

Parameters:
- W_IN, 21, input sample width (signed)
- W_OUT, 8, output sample width (signed)
- SHIFT, 6, arithmetic right-shift amount (1..W_IN-2)
- FRAME_LEN, 97, samples per frame (N-M+1)
- DEPTH, 4, output FIFO entries (power of 2, >=2)
- RELU_EN, 1, 1 = clamp negative results to 0 before saturation

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- s_data_in_y  in  W_IN  signed conv output sample
- s_valid_y  in  1  input sample valid
- s_ready_y  out  1  block can accept a sample
- m_data_out_z  out  W_OUT  signed requantized sample
- m_valid_z  out  1  output sample valid
- m_ready_z  in  1  consumer ready
- m_last_z  out  1  current output is sample FRAME_LEN-1 of its frame
- ovf_count  out  16  saturating count of clipped samples

Behaviour:
- Reset (async, active-high): FIFO empty, frame counter 0, ovf_count 0. Outputs during and after reset until the first write: s_ready_y=1, m_valid_z=0, m_data_out_z=0, m_last_z=0.
- Input handshake: a sample is accepted on a rising edge where s_valid_y && s_ready_y. s_ready_y = (fifo_count < DEPTH), derived from registered state only. It does not depend on m_ready_z.
- No bypass: when full, a pop in the same cycle does not enable a write. s_ready_y rises the cycle after the pop.
- Output handshake: an entry is popped on a rising edge where m_valid_z && m_ready_z. m_valid_z = (fifo_count != 0).
- m_data_out_z and m_last_z show the head entry. Both are 0 when the FIFO is empty.
- Output stays stable while m_valid_z && !m_ready_z.
- Latency: a sample accepted at edge k into an empty FIFO is visible with m_valid_z=1 after edge k (1 cycle). There is no combinational input-to-output path.
- Simultaneous push and pop (not full, not empty): both occur and fifo_count is unchanged. Order is strictly FIFO.
- Arithmetic, computed in W_IN+1 bits:
  - r = (y + 2^(SHIFT-1)) >>> SHIFT (round half toward +inf).
  - If RELU_EN and r<0, then r=0.
  - Saturate r to [-2^(W_OUT-1), 2^(W_OUT-1)-1].
  - Result is stored at write time.
- ovf_count increments by 1 on each accepted sample where saturation changed the value. It holds at 0xFFFF. A ReLU clamp alone does not count.
- Frame counter: increments on each accepted sample. The sample accepted with counter==FRAME_LEN-1 is stored with last=1, and the counter wraps to 0.
- m_last_z travels with its data through the FIFO.
- Reset mid-operation: all buffered samples are discarded and the frame position restarts at 0. Upstream and downstream must also be reset.
- X on s_data_in_y while s_valid_y=0 must not affect any state.

Test Plan:
- Single sample, defaults: y=96 -> z=2. y=-32 -> 0. y=-33 -> 0 (ReLU). 1-cycle latency. ovf_count=0.
- Full rate, m_ready_z=1, 97 consecutive samples -> 97 outputs, 1 per cycle. m_last_z=1 on the 97th only. The 98th output has m_last_z=0.
- Backpressure: m_ready_z=0, s_valid_y=1 -> 4 accepted, then s_ready_y=0.
  - Data held stable.
  - Raise m_ready_z for 1 cycle -> 1 pop; s_ready_y=1 the next cycle; order preserved.
- Saturation: y=20000 -> 127, ovf_count=1.
  - With RELU_EN=0: y=-10000 -> -128, ovf_count=2. y=-100 -> -2, no count.
- Reset asserted mid-frame (sample 40, FIFO holding 3) -> m_valid_z=0 immediately. Next frame's last is at the 97th sample after release.
- Drive the block from conv_128_32 with random valid/ready over 1000 iterations. Outputs must match the reference model exactly, with m_last_z every 97 outputs.

Source files
------------

// File: rtl/conv_out_requant.sv
// conv_out_requant: rounds, shifts, optionally ReLUs and saturates the
// conv_128_32 y stream to W_OUT bits, buffers the results in a FIFO and
// tags the last sample of each FRAME_LEN frame.
// Ports:
//   clk, reset            clock, async active-high reset
//   s_data_in_y/s_valid_y/s_ready_y   input sample stream
//   m_data_out_z/m_valid_z/m_ready_z/m_last_z   output stream
//   ovf_count             saturating count of clipped samples
module conv_out_requant #(
  parameter int W_IN      = 21,
  parameter int W_OUT     = 8,
  parameter int SHIFT     = 6,
  parameter int FRAME_LEN = 97,
  parameter int DEPTH     = 4,
  parameter int RELU_EN   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [W_IN-1:0]  s_data_in_y,
  input  logic                    s_valid_y,
  output logic                    s_ready_y,
  output logic signed [W_OUT-1:0] m_data_out_z,
  output logic                    m_valid_z,
  input  logic                    m_ready_z,
  output logic                    m_last_z,
  output logic [15:0]             ovf_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = $clog2(FRAME_LEN + 1);

  localparam logic signed [W_IN:0] RND =
    {{W_IN{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [W_IN:0] MAXV =
    (W_IN+1)'((1 << (W_OUT - 1)) - 1);
  // Two's complement: ~(2^(n-1)-1) == -2^(n-1)
  localparam logic signed [W_IN:0] MINV = ~MAXV;

  logic signed [W_IN:0] ext;
  logic signed [W_IN:0] sum;
  logic signed [W_IN:0] shr;
  logic signed [W_IN:0] rel;
  logic [W_OUT-1:0]     res;
  logic                 clip;

  logic [W_OUT:0]  mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [FW-1:0]   frame;
  logic            last_in;
  logic            push;
  logic            pop;

  always_comb begin
    ext  = {s_data_in_y[W_IN-1], s_data_in_y};
    sum  = ext + RND;
    shr  = sum >>> SHIFT;
    rel  = shr;
    if (RELU_EN != 0 && shr[W_IN]) rel = '0;
    clip = 1'b0;
    res  = rel[W_OUT-1:0];
    if (rel > MAXV) begin
      res  = MAXV[W_OUT-1:0];
      clip = 1'b1;
    end else if (rel < MINV) begin
      res  = MINV[W_OUT-1:0];
      clip = 1'b1;
    end
  end

  assign s_ready_y = count < CW'(DEPTH);
  assign m_valid_z = count != '0;
  assign push      = s_valid_y && s_ready_y;
  assign pop       = m_valid_z && m_ready_z;
  assign last_in   = frame == FW'(FRAME_LEN - 1);

  // Head entry is masked to zero while the FIFO is empty.
  assign m_data_out_z =
    m_valid_z ? mem[rd_ptr][W_OUT-1:0] : '0;
  assign m_last_z =
    m_valid_z ? mem[rd_ptr][W_OUT] : 1'b0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {last_in, res};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      frame     <= '0;
      ovf_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        frame  <= last_in ? '0 : frame + 1'b1;
        if (clip && ovf_count != 16'hFFFF)
          ovf_count <= ovf_count + 16'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
